// File: rtl/cop_exc_pkg.sv
// Shared constants and types for the CP0 exception sequencer.
package cop_exc_pkg;

  // ExcCode values written into CAUSE[6:2]
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BRK = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // CP0 register numbers (all sel 0)
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // STATUS bit indices
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_ERL = 2;
  localparam int ST_UM  = 4;
  localparam int ST_BEV = 22;

  // Sequencer state encodings
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_W_EPC    = 3'd1;
  localparam logic [2:0] S_W_CAUSE  = 3'd2;
  localparam logic [2:0] S_W_STATUS = 3'd3;
  localparam logic [2:0] S_REDIR    = 3'd4;

  // Qualified request lines into the priority encoder
  typedef struct packed {
    logic int_pend;
    logic ri;
    logic sys;
    logic brk;
    logic ov;
    logic eret;
  } exc_req_t;

  // Winning request
  typedef struct packed {
    logic       valid;
    logic [4:0] code;
    logic       is_eret;
  } exc_sel_t;

endpackage

// File: rtl/cop_exc_prio.sv
// Fixed-priority selection of the pending exception, interrupt or ERET.
module cop_exc_prio
  import cop_exc_pkg::*;
(
  input  exc_req_t req,
  output exc_sel_t sel
);

  // INT > RI > SYS > BRK > OV > ERET; an exception always masks a same-cycle ERET
  always_comb begin
    sel       = '0;
    sel.valid = 1'b1;
    if (req.int_pend)  sel.code = EXC_INT;
    else if (req.ri)   sel.code = EXC_RI;
    else if (req.sys)  sel.code = EXC_SYS;
    else if (req.brk)  sel.code = EXC_BRK;
    else if (req.ov)   sel.code = EXC_OV;
    else if (req.eret) sel.is_eret = 1'b1;
    else               sel.valid = 1'b0;
  end

endmodule

// File: rtl/cop_exc_ctrl.sv
// CP0 exception / interrupt / ERET sequencer: writes EPC, CAUSE, STATUS over
// successive cycles, then redirects fetch.
module cop_exc_ctrl
  import cop_exc_pkg::*;
#(
  parameter int          IRQ_W      = 6,
  parameter logic [31:0] VEC_NORMAL = 32'h8000_0180,
  parameter logic [31:0] VEC_BOOT   = 32'hBFC0_0380
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IRQ_W-1:0] irq,
  input  logic             ex_valid,
  input  logic             exc_ri,
  input  logic             exc_sys,
  input  logic             exc_brk,
  input  logic             exc_ov,
  input  logic             eret,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      status_in,
  input  logic [31:0]      epc_in,
  input  logic [31:0]      error_epc_in,
  output logic             cop_wr,
  output logic [4:0]       cop_num,
  output logic [2:0]       cop_sel,
  output logic [31:0]      cop_data,
  output logic             stall,
  output logic             flush,
  output logic             redirect,
  output logic [31:0]      redirect_pc
);

  logic [2:0]       state_q,  state_d;
  logic [31:0]      pc_q,     pc_d;
  logic [4:0]       code_q,   code_d;
  logic [IRQ_W-1:0] irq_q,    irq_d;
  logic [31:0]      status_q, status_d;
  logic [31:0]      tgt_q,    tgt_d;
  logic             eret_q,   eret_d;

  exc_req_t req;
  exc_sel_t sel;
  logic     int_pend;
  logic     accept;
  logic [31:0] cause_w;
  logic [31:0] status_w;

  // Interrupts are masked by IM, IE and suppressed while in EXL or ERL
  always_comb begin
    int_pend     = (|(irq & status_in[10 +: IRQ_W])) & status_in[ST_IE] &
                   ~status_in[ST_EXL] & ~status_in[ST_ERL];
    req.int_pend = int_pend;
    req.ri       = ex_valid & exc_ri;
    req.sys      = ex_valid & exc_sys;
    req.brk      = ex_valid & exc_brk;
    req.ov       = ex_valid & exc_ov;
    req.eret     = ex_valid & eret;
  end

  cop_exc_prio u_prio (
    .req (req),
    .sel (sel)
  );

  assign accept = (state_q == S_IDLE) & sel.valid & ~rst;

  // Next-state and capture of everything the sequence needs at accept
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    code_d   = code_q;
    irq_d    = irq_q;
    status_d = status_q;
    tgt_d    = tgt_q;
    eret_d   = eret_q;
    case (state_q)
      S_IDLE: begin
        if (sel.valid) begin
          pc_d     = ex_pc;
          code_d   = sel.code;
          irq_d    = irq;
          status_d = status_in;
          eret_d   = sel.is_eret;
          tgt_d    = status_in[ST_ERL] ? error_epc_in : epc_in;
          // Nested exception keeps the original EPC
          if (sel.is_eret)             state_d = S_W_STATUS;
          else if (status_in[ST_EXL])  state_d = S_W_CAUSE;
          else                         state_d = S_W_EPC;
        end
      end
      S_W_EPC:    state_d = S_W_CAUSE;
      S_W_CAUSE:  state_d = S_W_STATUS;
      S_W_STATUS: state_d = S_REDIR;
      S_REDIR:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State and latched request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      code_q   <= '0;
      irq_q    <= '0;
      status_q <= '0;
      tgt_q    <= '0;
      eret_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      code_q   <= code_d;
      irq_q    <= irq_d;
      status_q <= status_d;
      tgt_q    <= tgt_d;
      eret_q   <= eret_d;
    end
  end

  // CAUSE image and STATUS update value from the latched request
  always_comb begin
    cause_w             = '0;
    cause_w[10 +: IRQ_W] = irq_q;
    cause_w[6:2]        = code_q;
    status_w            = status_q;
    if (!eret_q)                status_w[ST_EXL] = 1'b1;
    else if (status_q[ST_ERL])  status_w[ST_ERL] = 1'b0;
    else                        status_w[ST_EXL] = 1'b0;
  end

  // CP0 write port, pipeline control and redirect; all quiet during reset
  always_comb begin
    cop_wr      = 1'b0;
    cop_num     = '0;
    cop_sel     = '0;
    cop_data    = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    flush       = accept;
    stall       = accept | ((state_q != S_IDLE) & ~rst);
    if (!rst) begin
      case (state_q)
        S_W_EPC: begin
          cop_wr   = 1'b1;
          cop_num  = CP0_EPC;
          cop_data = pc_q;
        end
        S_W_CAUSE: begin
          cop_wr   = 1'b1;
          cop_num  = CP0_CAUSE;
          cop_data = cause_w;
        end
        S_W_STATUS: begin
          cop_wr   = 1'b1;
          cop_num  = CP0_STATUS;
          cop_data = status_w;
        end
        S_REDIR: begin
          redirect    = 1'b1;
          redirect_pc = eret_q ? tgt_q : (status_q[ST_BEV] ? VEC_BOOT : VEC_NORMAL);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cop_exc_ctrl.sv
// Scoreboard bench for cop_exc_ctrl: expected CP0 writes / redirects are queued
// with their cycle offset from accept; a monitor pops and compares them.
module tb_cop_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  irq;
  logic        ex_valid, exc_ri, exc_sys, exc_brk, exc_ov, eret;
  logic [31:0] ex_pc, status_in, epc_in, error_epc_in;
  logic        cop_wr;
  logic [4:0]  cop_num;
  logic [2:0]  cop_sel;
  logic [31:0] cop_data;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;

  cop_exc_ctrl dut (
    .clk(clk), .rst(rst), .irq(irq), .ex_valid(ex_valid),
    .exc_ri(exc_ri), .exc_sys(exc_sys), .exc_brk(exc_brk), .exc_ov(exc_ov),
    .eret(eret), .ex_pc(ex_pc), .status_in(status_in), .epc_in(epc_in),
    .error_epc_in(error_epc_in), .cop_wr(cop_wr), .cop_num(cop_num),
    .cop_sel(cop_sel), .cop_data(cop_data), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [4:0]  num;
    logic [31:0] data;
    int          off;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  acc_cyc = 0;
  int  n_acc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: records accepts and checks every CP0 write / redirect
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (flush) begin
        acc_cyc = cyc;
        n_acc++;
      end
      if (cop_wr || redirect) begin
        logic [31:0] ad;
        ev_t e;
        ad = cop_wr ? cop_data : redirect_pc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event wr=%0b rd=%0b num=%0d data=%h off=%0d, required none",
                   cop_wr, redirect, cop_num, ad, cyc - acc_cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.rd != redirect || e.rd == cop_wr || e.num != cop_num || cop_sel != 3'd0 ||
              e.data != ad || e.off != cyc - acc_cyc) begin
            errors++;
            $display("FAIL event got rd=%0b wr=%0b num=%0d sel=%0d data=%h off=%0d, required rd=%0b num=%0d sel=0 data=%h off=%0d",
                     redirect, cop_wr, cop_num, cop_sel, ad, cyc - acc_cyc,
                     e.rd, e.num, e.data, e.off);
          end
        end
      end
    end
  end

  task automatic push(input bit rd, input logic [4:0] num, input logic [31:0] d, input int off);
    ev_t e;
    e.rd = rd; e.num = num; e.data = d; e.off = off;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  // One-cycle request, then inputs drop (the sequence must not depend on them)
  task automatic issue(input logic [5:0] i_irq, input logic v, input logic ri,
                       input logic sy, input logic bk, input logic ov,
                       input logic er, input logic [31:0] pc, input logic [31:0] st);
    @(posedge clk); #1;
    irq = i_irq; ex_valid = v; exc_ri = ri; exc_sys = sy; exc_brk = bk;
    exc_ov = ov; eret = er; ex_pc = pc; status_in = st;
    @(posedge clk); #1;
    irq = '0; ex_valid = 0; exc_ri = 0; exc_sys = 0; exc_brk = 0;
    exc_ov = 0; eret = 0; ex_pc = '0; status_in = '0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (!stall) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle got stall=1 after 30 cycles, required stall=0", name);
    end
  endtask

  task automatic drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained got %0d pending events, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int n0;
    bit found;
    rst = 1; irq = '0; ex_valid = 0; exc_ri = 0; exc_sys = 0; exc_brk = 0;
    exc_ov = 0; eret = 0; ex_pc = '0; status_in = '0;
    epc_in = 32'h1234; error_epc_in = 32'hABCD;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", {28'd0, cop_wr, stall, flush, redirect}, 32'd0);
    check("reset_data", cop_data | redirect_pc, 32'd0);
    rst = 0;

    // SYSCALL
    push(0, 5'd14, 32'h0040_0020, 1);
    push(0, 5'd13, 32'h0000_0020, 2);
    push(0, 5'd12, 32'h0000_FC03, 3);
    push(1, 5'd0,  32'h8000_0180, 4);
    issue(6'b0, 1, 0, 1, 0, 0, 0, 32'h0040_0020, 32'h0000_FC01);
    wait_idle("sys"); drained("sys");

    // IRQ2 with BEV
    push(0, 5'd14, 32'h0000_0100, 1);
    push(0, 5'd13, 32'h0000_1000, 2);
    push(0, 5'd12, 32'h0040_1003, 3);
    push(1, 5'd0,  32'hBFC0_0380, 4);
    issue(6'b000100, 0, 0, 0, 0, 0, 0, 32'h0000_0100, 32'h0040_1001);
    wait_idle("irq"); drained("irq");

    // IRQ with IE=0: nothing happens
    n0 = n_acc;
    issue(6'b000100, 0, 0, 0, 0, 0, 0, 32'h0000_0100, 32'h0040_1000);
    repeat (6) @(negedge clk);
    check("irq_ie0_accepts", n_acc, n0);
    check("irq_ie0_stall", {31'd0, stall}, 32'd0);
    drained("irq_ie0");

    // RI + OV together: RI wins
    push(0, 5'd14, 32'h0000_0200, 1);
    push(0, 5'd13, 32'h0000_0028, 2);
    push(0, 5'd12, 32'h0000_0002, 3);
    push(1, 5'd0,  32'h8000_0180, 4);
    issue(6'b0, 1, 1, 0, 0, 1, 0, 32'h0000_0200, 32'h0);
    wait_idle("ri_ov"); drained("ri_ov");

    // ERET + SYSCALL together: SYSCALL wins
    push(0, 5'd14, 32'h0000_0300, 1);
    push(0, 5'd13, 32'h0000_0020, 2);
    push(0, 5'd12, 32'h0000_0002, 3);
    push(1, 5'd0,  32'h8000_0180, 4);
    issue(6'b0, 1, 0, 1, 0, 0, 1, 32'h0000_0300, 32'h0);
    wait_idle("eret_sys"); drained("eret_sys");

    // Nested BREAK with EXL=1: EPC untouched, redirect one cycle earlier
    push(0, 5'd13, 32'h0000_0024, 1);
    push(0, 5'd12, 32'h0000_0002, 2);
    push(1, 5'd0,  32'h8000_0180, 3);
    issue(6'b0, 1, 0, 0, 1, 0, 0, 32'h0000_0400, 32'h0000_0002);
    wait_idle("nested"); drained("nested");

    // ERET, EXL|IE set, ERL clear: clear EXL, return to EPC
    push(0, 5'd12, 32'h0000_0001, 1);
    push(1, 5'd0,  32'h0000_1234, 2);
    issue(6'b0, 1, 0, 0, 0, 0, 1, 32'h0000_0500, 32'h0000_0003);
    wait_idle("eret3"); drained("eret3");

    // ERET, EXL only
    push(0, 5'd12, 32'h0000_0000, 1);
    push(1, 5'd0,  32'h0000_1234, 2);
    issue(6'b0, 1, 0, 0, 0, 0, 1, 32'h0000_0500, 32'h0000_0002);
    wait_idle("eret2"); drained("eret2");

    // ERET with ERL set: clear ERL, return to ErrorEPC
    push(0, 5'd12, 32'h0000_0002, 1);
    push(1, 5'd0,  32'h0000_ABCD, 2);
    issue(6'b0, 1, 0, 0, 0, 0, 1, 32'h0000_0500, 32'h0000_0006);
    wait_idle("eret6"); drained("eret6");

    // Reset during W_CAUSE aborts the sequence
    push(0, 5'd14, 32'h0000_0600, 1);
    push(0, 5'd13, 32'h0000_0020, 2);
    issue(6'b0, 1, 0, 1, 0, 0, 0, 32'h0000_0600, 32'h0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #1;
      if (cop_wr && cop_num == 5'd13) found = 1;
    end
    check("rst_seq_reached_cause", {31'd0, found}, 32'd1);
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_ctl", {28'd0, cop_wr, stall, flush, redirect}, 32'd0);
    rst = 0;
    @(posedge clk); #1;
    check("rst_after_ctl", {28'd0, cop_wr, stall, flush, redirect}, 32'd0);
    repeat (6) @(negedge clk);
    check("rst_after_stall", {31'd0, stall}, 32'd0);
    drained("rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running required finished");
    $fatal(1);
  end

endmodule
